// File: rtl/io_write_port_buffer_if.sv
// Write-port side and consumer side of one I/O write port buffer.
// The buffer connects through the slave modport; whatever drives it connects through master.
interface io_write_port_buffer_if #(
    parameter int WORD_WIDTH = 36,
    parameter int PTR_WIDTH  = 3
);
    logic                  active_in;
    logic [WORD_WIDTH-1:0] data_in;
    logic                  empty_full;
    logic [WORD_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [PTR_WIDTH:0]    count;
    logic                  overflow;
    logic                  overflow_clear;

    modport slave (
        input  active_in, data_in, out_ready, overflow_clear,
        output empty_full, out_data, out_valid, count, overflow
    );

    modport master (
        output active_in, data_in, out_ready, overflow_clear,
        input  empty_full, out_data, out_valid, count, overflow
    );
endinterface

// File: rtl/io_write_port_buffer.sv
// Elastic FIFO for one I/O write port: a RAM of DEPTH-1 words in front of an output register,
// with a valid/ready consumer side and a registered EmptyFull status back to the write stage.
module io_write_port_buffer #(
    parameter int WORD_WIDTH = 36,
    parameter int DEPTH      = 8,
    parameter int PTR_WIDTH  = 3,
    parameter int HEADROOM   = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    io_write_port_buffer_if.slave port
);
    localparam logic [PTR_WIDTH-1:0] LAST_IDX  = PTR_WIDTH'(DEPTH - 2);
    localparam logic [PTR_WIDTH:0]   DEPTH_C   = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0]   FULL_MARK = (PTR_WIDTH+1)'(DEPTH - HEADROOM);

    logic [WORD_WIDTH-1:0] ram_mem [0:DEPTH-2];

    logic [PTR_WIDTH-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_WIDTH-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [PTR_WIDTH:0]    count_reg, count_next;
    logic [WORD_WIDTH-1:0] out_data_reg, out_data_next;
    logic                  out_valid_reg, out_valid_next;
    logic                  empty_full_reg, empty_full_next;
    logic                  overflow_reg, overflow_next;

    logic                  push, pop, ram_we, ram_load, ram_empty;
    logic [PTR_WIDTH:0]    ram_count;

    // Pointers wrap at the last RAM slot rather than rolling over, since the RAM holds DEPTH-1 words.
    function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    always_comb begin
        pop             = out_valid_reg & port.out_ready;
        push            = port.active_in & ((count_reg < DEPTH_C) | pop);
        ram_count       = count_reg - {{PTR_WIDTH{1'b0}}, out_valid_reg};
        ram_empty       = (ram_count == '0);

        ram_we          = 1'b0;
        ram_load        = 1'b0;
        out_data_next   = out_data_reg;
        out_valid_next  = out_valid_reg;
        wr_ptr_next     = wr_ptr_reg;
        rd_ptr_next     = rd_ptr_reg;

        if (!out_valid_reg) begin
            if (push) begin
                out_data_next  = port.data_in;
                out_valid_next = 1'b1;
            end
        end else if (pop) begin
            if (!ram_empty) begin
                // When full, the write and read slots coincide; the load still sees the old word.
                ram_load    = 1'b1;
                rd_ptr_next = next_ptr(rd_ptr_reg);
                ram_we      = push;
            end else if (push) begin
                out_data_next = port.data_in;
            end else begin
                out_valid_next = 1'b0;
            end
        end else begin
            ram_we = push;
        end

        if (ram_we) begin
            wr_ptr_next = next_ptr(wr_ptr_reg);
        end

        count_next      = count_reg + (PTR_WIDTH+1)'(push) - (PTR_WIDTH+1)'(pop);
        empty_full_next = (count_next >= FULL_MARK);

        overflow_next = overflow_reg;
        if (port.overflow_clear) begin
            overflow_next = 1'b0;
        end else if (port.active_in && !push) begin
            overflow_next = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (ram_we) begin
            ram_mem[wr_ptr_reg] <= port.data_in;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            out_data_reg   <= '0;
            out_valid_reg  <= 1'b0;
            empty_full_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            out_data_reg   <= ram_load ? ram_mem[rd_ptr_reg] : out_data_next;
            out_valid_reg  <= out_valid_next;
            empty_full_reg <= empty_full_next;
            overflow_reg   <= overflow_next;
        end
    end

    assign port.out_data   = out_data_reg;
    assign port.out_valid  = out_valid_reg;
    assign port.count      = count_reg;
    assign port.empty_full = empty_full_reg;
    assign port.overflow   = overflow_reg;
endmodule
